// File: rtl/jogo_pkg.sv
// jogo_pkg: shared constants and FSM state encoding for the memory game
package jogo_pkg;
  localparam int T_ACESO_PADRAO = 500;
  localparam int T_APAGADO_PADRAO = 250;
  localparam int SEQ_W = 4;
  localparam int ENDERECO_W_PADRAO = 4;
  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    CARREGA = 4'd2,
    ACESO   = 4'd3,
    APAGADO = 4'd4,
    PROXIMO = 4'd5,
    FIM     = 4'd6
  } estado_t;
endpackage

// File: rtl/contador_intervalo.sv
// contador_intervalo: up-counter with sync clear, enable and terminal flag at a runtime limit
module contador_intervalo #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);
  logic [W-1:0] valor;
  always_ff @(posedge clock)
    if (reset || limpa) valor <= '0;
    else if (conta) valor <= valor + 1'b1;
  assign fim = valor == limite;
endmodule

// File: rtl/controle_exibicao_sequencia.sv
// controle_exibicao_sequencia: plays the sequence ROM on the LEDs with fixed on-time and dark gap
module controle_exibicao_sequencia
  import jogo_pkg::*;
#(
  parameter int T_ACESO = T_ACESO_PADRAO,
  parameter int T_APAGADO = T_APAGADO_PADRAO,
  parameter int ENDERECO_W = ENDERECO_W_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  cancelar,
  input  logic [ENDERECO_W-1:0] limite,
  input  logic [SEQ_W-1:0]      dado_memoria,
  output logic [ENDERECO_W-1:0] endereco,
  output logic [SEQ_W-1:0]      leds,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [3:0]            db_estado
);
  localparam int T_MAX = T_ACESO > T_APAGADO ? T_ACESO : T_APAGADO;
  localparam int TW = T_MAX > 1 ? $clog2(T_MAX) : 1;
  estado_t estado, prox;
  logic [ENDERECO_W-1:0] limite_reg;
  logic [TW-1:0] lim_t;
  logic fim_t, limpa_t, conta_t, fim_aceso;
  always_ff @(posedge clock)
    if (reset) estado <= INICIAL;
    else estado <= prox;
  always_comb begin
    case (estado)
      INICIAL: prox = iniciar ? PREPARA : INICIAL;
      PREPARA: prox = CARREGA;
      CARREGA: prox = ACESO;
      ACESO:   prox = fim_t ? APAGADO : ACESO;
      APAGADO: prox = !fim_t ? APAGADO : (endereco == limite_reg ? FIM : PROXIMO);
      PROXIMO: prox = CARREGA;
      default: prox = INICIAL;
    endcase
    if (cancelar) prox = INICIAL;
  end
  always_comb begin
    ocupado = estado != INICIAL;
    pronto = estado == FIM;
    db_estado = estado;
    fim_aceso = (estado == ACESO) && fim_t;
    conta_t = (estado == ACESO) || (estado == APAGADO);
    // timer restarts on entry to both ACESO (cleared in CARREGA) and APAGADO
    limpa_t = !conta_t || fim_aceso;
    lim_t = estado == ACESO ? TW'(T_ACESO - 1) : TW'(T_APAGADO - 1);
  end
  contador_intervalo #(.W(TW)) u_temporizador (
    .clock(clock),
    .reset(reset),
    .limpa(limpa_t),
    .conta(conta_t),
    .limite(lim_t),
    .fim(fim_t)
  );
  // leds are cleared on the ACESO->APAGADO edge so the on-time is exactly T_ACESO
  always_ff @(posedge clock)
    if (reset) begin
      endereco <= '0;
      leds <= '0;
      limite_reg <= '0;
    end else begin
      if (!cancelar && estado == PREPARA) begin
        endereco <= '0;
        limite_reg <= limite;
      end else if (!cancelar && estado == PROXIMO) endereco <= endereco + 1'b1;
      leds <= cancelar ? '0 : estado == CARREGA ? dado_memoria : fim_aceso ? '0 : leds;
    end
endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// tb_controle_exibicao_sequencia: scoreboard bench, driver queues expectations and a monitor checks them
module tb_controle_exibicao_sequencia;
  typedef struct {
    int ciclo;
    logic [3:0] leds;
    logic [3:0] endereco;
  } ev_t;
  typedef struct {
    int ciclo;
    logic [3:0] leds;
    logic [3:0] endereco;
    logic [3:0] estado;
    logic ocupado;
    logic pronto;
  } snap_t;
  logic clock = 0;
  logic reset, iniciar, cancelar;
  logic [3:0] limite, dado_memoria, endereco, leds, db_estado;
  logic ocupado, pronto;
  logic [3:0] rom [16];
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  bit fim_tb = 0;
  ev_t q_ev[$];
  int q_pr[$];
  snap_t q_snap[$];
  controle_exibicao_sequencia #(.T_ACESO(4), .T_APAGADO(2), .ENDERECO_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .cancelar(cancelar),
    .limite(limite),
    .dado_memoria(dado_memoria),
    .endereco(endereco),
    .leds(leds),
    .ocupado(ocupado),
    .pronto(pronto),
    .db_estado(db_estado)
  );
  assign dado_memoria = rom[endereco];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string n, input int a, input int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", n, a, e, cyc);
    end
  endtask
  // monitor: compares whatever the DUT presents against the queued expectations
  logic [3:0] prev = 0;
  logic [3:0] cur = 0;
  bit pos_fim = 0;
  always @(negedge clock) begin
    ev_t ev;
    snap_t s;
    if (db_estado == 4'd3 && prev != 4'd3) begin
      if (q_ev.size() == 0) chk("aceso_inesperado", 1, 0);
      else begin
        ev = q_ev.pop_front();
        chk("aceso_ciclo", cyc, ev.ciclo);
        chk("aceso_leds", int'(leds), int'(ev.leds));
        chk("aceso_endereco", int'(endereco), int'(ev.endereco));
        cur = ev.leds;
      end
    end else if (db_estado == 4'd3) chk("aceso_estavel", int'(leds), int'(cur));
    if (db_estado == 4'd4) chk("apagado_leds", int'(leds), 0);
    if (pos_fim) chk("ocioso_pos_fim", int'(ocupado), 0);
    pos_fim = pronto;
    if (pronto) begin
      if (q_pr.size() == 0) chk("pronto_inesperado", 1, 0);
      else chk("pronto_ciclo", cyc, q_pr.pop_front());
    end
    if (q_snap.size() > 0 && q_snap[0].ciclo <= cyc) begin
      s = q_snap.pop_front();
      chk("snap_ciclo", cyc, s.ciclo);
      chk("snap_leds", int'(leds), int'(s.leds));
      chk("snap_endereco", int'(endereco), int'(s.endereco));
      chk("snap_estado", int'(db_estado), int'(s.estado));
      chk("snap_ocupado", int'(ocupado), int'(s.ocupado));
      chk("snap_pronto", int'(pronto), int'(s.pronto));
    end
    prev = db_estado;
    if (fim_tb) begin
      chk("fila_eventos", q_ev.size(), 0);
      chk("fila_pronto", q_pr.size(), 0);
      chk("fila_snap", q_snap.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
    end
  end
  task automatic snap_ocioso(input int c, input logic [3:0] e);
    snap_t s;
    s.ciclo = c;
    s.leds = 4'd0;
    s.endereco = e;
    s.estado = 4'd0;
    s.ocupado = 1'b0;
    s.pronto = 1'b0;
    q_snap.push_back(s);
  endtask
  task automatic start_run(input int lim, input int nshow, input bit done, input int hold);
    ev_t e;
    int e0;
    @(negedge clock);
    e0 = cyc + 1;
    for (int k = 0; k < nshow; k++) begin
      e.ciclo = e0 + 2 + 8 * k;
      e.leds = rom[k];
      e.endereco = 4'(k);
      q_ev.push_back(e);
    end
    if (done) q_pr.push_back(e0 + 8 * (lim + 1));
    limite = 4'(lim);
    iniciar = 1;
    repeat (hold) @(negedge clock);
    iniciar = 0;
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while (ocupado) begin
      @(negedge clock);
      n++;
      if (n > 300) begin
        $display("FAIL timeout_ocioso: ocupado still high after %0d cycles", n);
        $fatal(1);
      end
    end
    snap_ocioso(cyc + 1, 4'(lim));
    repeat (2) @(negedge clock);
  endtask
  task automatic wait_state(input logic [3:0] e, input logic [3:0] a);
    int n = 0;
    while (!(db_estado == e && endereco == a)) begin
      @(negedge clock);
      n++;
      if (n > 300) begin
        $display("FAIL timeout_estado: state %0d addr %0d never seen", e, a);
        $fatal(1);
      end
    end
  endtask
  initial begin
    logic [3:0] init_rom [16] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8,
                                  4'h3, 4'h5, 4'h0, 4'h9, 4'h6, 4'hC, 4'hA, 4'hF};
    rom = init_rom;
    reset = 1;
    iniciar = 0;
    cancelar = 0;
    limite = 0;
    @(negedge clock);
    snap_ocioso(cyc + 1, 4'd0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    start_run(0, 1, 1, 1);
    wait_idle(0);
    for (int l = 1; l <= 7; l++) begin
      start_run(l, l + 1, 1, 1);
      wait_idle(l);
    end
    start_run(15, 16, 1, 1);
    wait_idle(15);
    start_run(5, 3, 0, 1);
    wait_state(4'd3, 4'd2);
    cancelar = 1;
    snap_ocioso(cyc + 1, 4'd2);
    @(negedge clock);
    cancelar = 0;
    @(negedge clock);
    start_run(5, 6, 1, 1);
    wait_idle(5);
    start_run(1, 2, 1, 5);
    repeat (3) @(negedge clock);
    limite = 4'd7;
    wait_idle(1);
    start_run(3, 2, 0, 1);
    wait_state(4'd4, 4'd1);
    reset = 1;
    snap_ocioso(cyc + 1, 4'd0);
    @(negedge clock);
    reset = 0;
    repeat (3) @(negedge clock);
    fim_tb = 1;
  end
endmodule
